sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single 8-bit data SRAM between two requesters: the processor core (port 0) and an external DMA/loader port (port 1).
- Sits between the requesters and the SRAM's address, read, write and data pins.
- Accepts requests over a req/ack handshake, chooses between them with round-robin arbitration, and sequences each access through a small state machine with a programmable number of wait states.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
- AW, 8, address width in bits.
- DW, 8, data width in bits.
- WAIT_STATES, 0, extra cycles the SRAM strobe is held (0..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req0  input  1  port 0 (core) access request.
- We0  input  1  port 0 write enable; 1 = write, 0 = read.
- Addr0  input  AW  port 0 address.
- Wdata0  input  DW  port 0 write data.
- Ack0  output  1  port 0 access complete; one-cycle pulse.
- Rdata0  output  DW  port 0 read data; valid while Ack0=1.
- Req1, We1, Addr1, Wdata1, Ack1, Rdata1: same set of signals for port 1 (DMA).
- SRAMAddress  output  AW  address driven to the SRAM.
- SRAMRead  output  1  SRAM read strobe.
- SRAMWrite  output  1  SRAM write strobe.
- SRAM_Datain  output  DW  write data to the SRAM.
- SRAM_Dataout  input  DW  read data from the SRAM; valid one cycle after the SRAMRead edge.
- Busy  output  1  high in every state except IDLE.
- Owner  output  1  port currently granted; holds the last granted port when idle.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = IDLE.
  - Ack0, Ack1, SRAMRead, SRAMWrite, Busy all 0.
  - SRAMAddress, SRAM_Datain, Rdata0, Rdata1 all 0.
  - Owner = 1, so port 0 wins the first contention.
  - Wait counter = 0.
  - An access in flight is abandoned: no ack is issued and the strobes drop immediately.
- States: IDLE, ACCESS, CAPTURE, DONE.
- IDLE:
  - Req0/Req1 are sampled at each rising edge.
  - If only one request is high, grant it.
  - If both are high, grant the port that is not Owner (round-robin).
  - On grant: latch the winner's We, Addr and Wdata into the SRAMAddress/SRAM_Datain registers, update Owner, load the wait counter with WAIT_STATES, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - SRAMRead = ~We_latched; SRAMWrite = We_latched.
  - Address and data held stable.
  - If counter ≠ 0, decrement and stay; if counter = 0, go to CAPTURE.
  - Strobe width is 1+WAIT_STATES cycles.
- CAPTURE:
  - Strobes are 0.
  - On a read, SRAM_Dataout is registered into the Rdata of the owning port at the exiting edge.
  - Then go to DONE.
- DONE:
  - The owning port's Ack = 1 for exactly one cycle; the other port's Ack stays 0.
  - Rdata holds its value until that port's next access.
  - Then go to IDLE.
- Latency: Req sampled at edge N (IDLE) → Ack high in cycle N+3+WAIT_STATES. Throughput is one access per 4+WAIT_STATES cycles.
- Handshake rules for requesters:
  - Hold Req, We, Addr and Wdata stable from Req rise until Ack.
  - Drop Req no later than the cycle after Ack.
  - A Req still high when the arbiter is back in IDLE is treated as a new access. This is legal back-to-back, but under contention the other port wins it.
- Inputs are ignored outside IDLE. A losing or late request simply waits; it is never lost while held.
- Req falling before its Ack: the access still completes and Ack still pulses. The requester must ignore it.
- Writes: Rdata is unchanged.
- Address and data are full-width pass-through; no wrap or arithmetic is applied.
- Only one strobe is ever high. SRAMRead and SRAMWrite are never both 1.

Test Plan:
- Reset release, port 0 writes Addr0=8'h10, Wdata0=8'hA5 (WAIT_STATES=0):
  - SRAMWrite=1 for exactly one cycle with SRAMAddress=8'h10, SRAM_Datain=8'hA5.
  - Ack0 pulses 3 cycles after the Req0 sample; Ack1 stays 0.
- Port 1 reads 8'h10 with the SRAM model returning 8'hA5:
  - SRAMRead=1 for one cycle.
  - Rdata1=8'hA5 while Ack1=1; Owner=1.
- Req0 and Req1 held high simultaneously for 4 accesses after reset:
  - Grant order is 0,1,0,1.
  - Each Ack pulse is exactly one cycle; Busy drops only after the final DONE.
- WAIT_STATES=3, single read:
  - SRAMRead high for 4 consecutive cycles.
  - Ack arrives 6 cycles after the Req sample.
- Reset asserted during ACCESS of a write:
  - SRAMWrite, Busy and the acks go to 0 immediately, without waiting for a clock edge.
  - No ack is issued; after release the first access goes to port 0.
- Req0 dropped one cycle after grant:
  - Access completes and Ack0 pulses once.
  - Arbiter returns to IDLE and does not re-grant port 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data SRAM.
// Each granted access runs IDLE -> ACCESS -> CAPTURE -> DONE.
module sram_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Req0,
    input  logic          We0,
    input  logic [AW-1:0] Addr0,
    input  logic [DW-1:0] Wdata0,
    output logic          Ack0,
    output logic [DW-1:0] Rdata0,
    input  logic          Req1,
    input  logic          We1,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] Wdata1,
    output logic          Ack1,
    output logic [DW-1:0] Rdata1,
    output logic [AW-1:0] SRAMAddress,
    output logic          SRAMRead,
    output logic          SRAMWrite,
    output logic [DW-1:0] SRAM_Datain,
    input  logic [DW-1:0] SRAM_Dataout,
    output logic          Busy,
    output logic          Owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state;
    state_t        next_state;
    logic          grant;
    logic          grant_port;
    logic          owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic [3:0]    cnt;

    // Under contention the port that did not win last time gets the grant
    always_comb begin
        grant      = Req0 | Req1;
        grant_port = (Req0 & Req1) ? ~owner : Req1;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant) next_state = ACCESS;
            ACCESS:  if (cnt == 4'd0) next_state = CAPTURE;
            CAPTURE: next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state != IDLE);
        SRAMRead  = (state == ACCESS) & ~we_q;
        SRAMWrite = (state == ACCESS) & we_q;
        Ack0      = (state == DONE) & ~owner;
        Ack1      = (state == DONE) & owner;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            owner    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt      <= 4'd0;
        end else begin
            if (state == IDLE && grant) begin
                owner   <= grant_port;
                we_q    <= grant_port ? We1 : We0;
                addr_q  <= grant_port ? Addr1 : Addr0;
                wdata_q <= grant_port ? Wdata1 : Wdata0;
                cnt     <= WS;
            end
            if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == CAPTURE && !we_q) begin
                if (owner) rdata1_q <= SRAM_Dataout;
                else       rdata0_q <= SRAM_Dataout;
            end
        end
    end

    assign Owner       = owner;
    assign SRAMAddress = addr_q;
    assign SRAM_Datain = wdata_q;
    assign Rdata0      = rdata0_q;
    assign Rdata1      = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (0 and 3 wait states)
// compared every cycle against a phase-counting reference model.
module tb_sram_port_arbiter;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fill;
    logic       req   [2][2];
    logic       we    [2][2];
    logic [7:0] addr  [2][2];
    logic [7:0] wdata [2][2];
    logic       ack   [2][2];
    logic [7:0] rdata [2][2];
    logic [7:0] saddr [2];
    logic [7:0] sdin  [2];
    logic [7:0] sdout [2];
    logic       sread [2];
    logic       swrite[2];
    logic       busy  [2];
    logic       owner [2];
    logic [7:0] smem  [2][256];

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(8), .DW(8), .WAIT_STATES(WS0)) u0 (
        .clk(clk), .Reset(rst_n),
        .Req0(req[0][0]), .We0(we[0][0]),
        .Addr0(addr[0][0]), .Wdata0(wdata[0][0]),
        .Ack0(ack[0][0]), .Rdata0(rdata[0][0]),
        .Req1(req[0][1]), .We1(we[0][1]),
        .Addr1(addr[0][1]), .Wdata1(wdata[0][1]),
        .Ack1(ack[0][1]), .Rdata1(rdata[0][1]),
        .SRAMAddress(saddr[0]), .SRAMRead(sread[0]),
        .SRAMWrite(swrite[0]), .SRAM_Datain(sdin[0]),
        .SRAM_Dataout(sdout[0]),
        .Busy(busy[0]), .Owner(owner[0])
    );

    sram_port_arbiter #(.AW(8), .DW(8), .WAIT_STATES(WS1)) u1 (
        .clk(clk), .Reset(rst_n),
        .Req0(req[1][0]), .We0(we[1][0]),
        .Addr0(addr[1][0]), .Wdata0(wdata[1][0]),
        .Ack0(ack[1][0]), .Rdata0(rdata[1][0]),
        .Req1(req[1][1]), .We1(we[1][1]),
        .Addr1(addr[1][1]), .Wdata1(wdata[1][1]),
        .Ack1(ack[1][1]), .Rdata1(rdata[1][1]),
        .SRAMAddress(saddr[1]), .SRAMRead(sread[1]),
        .SRAMWrite(swrite[1]), .SRAM_Datain(sdin[1]),
        .SRAM_Dataout(sdout[1]),
        .Busy(busy[1]), .Owner(owner[1])
    );

    // SRAM: read data registered one cycle after the read strobe edge
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fill) begin
                for (int k = 0; k < 256; k++)
                    smem[i][k] <= 8'(k) ^ 8'h5A;
            end else begin
                if (swrite[i]) smem[i][saddr[i]] <= sdin[i];
                if (sread[i])  sdout[i] <= smem[i][saddr[i]];
            end
        end
    end

    // Reference model: t = cycles since grant, -1 when idle
    int         t      [2];
    logic       m_own  [2];
    int         lport  [2];
    logic       lwe    [2];
    logic [7:0] laddr  [2];
    logic [7:0] ldata  [2];
    logic [7:0] m_rd   [2][2];
    logic [7:0] mmem   [2][256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic hold_mode = 1'b0;
    logic rnd_en = 1'b0;
    int nacc   [2];
    int nack   [2][2];
    int strobes[2];
    int ack_cyc[2];
    logic [7:0] ack_rd[2];
    int order  [2][$];

    function automatic int wsof(int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    function automatic logic e_ack(int i, int p);
        return t[i] == wsof(i) + 2 && lport[i] == p;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            t[i]     = -1;
            m_own[i] = 1'b1;
            lport[i] = 1;
            lwe[i]   = 1'b0;
            laddr[i] = 8'h00;
            ldata[i] = 8'h00;
            m_rd[i][0] = 8'h00;
            m_rd[i][1] = 8'h00;
            req[i][0] = 1'b0;
            req[i][1] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int w = wsof(i);
                if (t[i] < 0) begin
                    if (req[i][0] || req[i][1]) begin
                        int p;
                        if (req[i][0] && req[i][1])
                            p = m_own[i] ? 0 : 1;
                        else
                            p = req[i][1] ? 1 : 0;
                        m_own[i] = (p == 1);
                        lport[i] = p;
                        lwe[i]   = we[i][p];
                        laddr[i] = addr[i][p];
                        ldata[i] = wdata[i][p];
                        t[i]     = 0;
                    end
                end else begin
                    if (t[i] <= w && lwe[i])
                        mmem[i][laddr[i]] = ldata[i];
                    if (t[i] == w + 1 && !lwe[i])
                        m_rd[i][lport[i]] = mmem[i][laddr[i]];
                    t[i] = (t[i] == w + 2) ? -1 : t[i] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int   w  = wsof(i);
            logic st = t[i] >= 0 && t[i] <= w;
            chk($sformatf("busy%0d", i),
                int'(busy[i]), int'(t[i] >= 0));
            chk($sformatf("sread%0d", i),
                int'(sread[i]), int'(st && !lwe[i]));
            chk($sformatf("swrite%0d", i),
                int'(swrite[i]), int'(st && lwe[i]));
            chk($sformatf("saddr%0d", i),
                int'(saddr[i]), int'(laddr[i]));
            chk($sformatf("sdin%0d", i),
                int'(sdin[i]), int'(ldata[i]));
            chk($sformatf("owner%0d", i),
                int'(owner[i]), int'(m_own[i]));
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("ack%0d_%0d", i, p),
                    int'(ack[i][p]), int'(e_ack(i, p)));
                chk($sformatf("rdata%0d_%0d", i, p),
                    int'(rdata[i][p]), int'(m_rd[i][p]));
            end
        end
    endtask

    task automatic raise(int i, int p, logic w,
                         logic [7:0] a, logic [7:0] d);
        req[i][p]   = 1'b1;
        we[i][p]    = w;
        addr[i][p]  = a;
        wdata[i][p] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
        for (int i = 0; i < 2; i++) begin
            if (sread[i] || swrite[i]) strobes[i]++;
            for (int p = 0; p < 2; p++) begin
                if (ack[i][p]) begin
                    ack_cyc[i] = cyc;
                    ack_rd[i]  = rdata[i][p];
                    order[i].push_back(p);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (e_ack(i, p)) begin
                    nacc[i]++;
                    nack[i][p]++;
                    if (!hold_mode) req[i][p] = 1'b0;
                end else if (rnd_en && !req[i][p] &&
                             $urandom_range(0, 3) == 0) begin
                    raise(i, p, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)),
                          8'($urandom));
                end
            end
            if (hold_mode && nacc[i] >= 4) begin
                req[i][0] = 1'b0;
                req[i][1] = 1'b0;
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            nacc[i] = 0;
            nack[i][0] = 0;
            nack[i][1] = 0;
            strobes[i] = 0;
            ack_cyc[i] = -100;
            ack_rd[i]  = 8'h00;
            order[i].delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int sc;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                we[i][p]    = 1'b0;
                addr[i][p]  = 8'h00;
                wdata[i][p] = 8'h00;
            end
            for (int k = 0; k < 256; k++)
                mmem[i][k] = 8'(k) ^ 8'h5A;
        end
        model_reset();
        clear_stats();
        fill  = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        tick();
        fill  = 1'b0;
        rst_n = 1'b1;

        // single write from port 0
        clear_stats();
        for (int i = 0; i < 2; i++)
            raise(i, 0, 1'b1, 8'h10, 8'hA5);
        sc = cyc + 1;
        repeat (9) tick();
        chk("wr_strobe_ws0", strobes[0], 1);
        chk("wr_strobe_ws3", strobes[1], 4);
        chk("wr_lat_ws0", ack_cyc[0] - sc + 1, 3);
        chk("wr_lat_ws3", ack_cyc[1] - sc + 1, 6);
        chk("wr_acks_ws0", order[0].size(), 1);

        // port 1 reads back the written byte
        clear_stats();
        for (int i = 0; i < 2; i++)
            raise(i, 1, 1'b0, 8'h10, 8'h00);
        sc = cyc + 1;
        repeat (9) tick();
        chk("rd_strobe_ws0", strobes[0], 1);
        chk("rd_strobe_ws3", strobes[1], 4);
        chk("rd_lat_ws3", ack_cyc[1] - sc + 1, 6);
        chk("rd_data_ws0", int'(ack_rd[0]), 8'hA5);
        chk("rd_data_ws3", int'(ack_rd[1]), 8'hA5);
        chk("rd_owner_ws0", int'(owner[0]), 1);

        // permanent contention after reset
        do_reset();
        clear_stats();
        hold_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            raise(i, 0, 1'b0, 8'h10, 8'h00);
            raise(i, 1, 1'b1, 8'h30, 8'h77);
        end
        repeat (36) tick();
        hold_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rr_cnt%0d", i), order[i].size(), 4);
            if (order[i].size() == 4) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("rr_ord%0d_%0d", i, k),
                        order[i][k], k % 2);
            end
        end

        // asynchronous reset in the middle of a write
        clear_stats();
        for (int i = 0; i < 2; i++)
            raise(i, 0, 1'b1, 8'h20, 8'h3C);
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ar_swrite%0d", i), int'(swrite[i]), 0);
            chk($sformatf("ar_busy%0d", i), int'(busy[i]), 0);
            chk($sformatf("ar_ack0_%0d", i), int'(ack[i][0]), 0);
            chk($sformatf("ar_ack1_%0d", i), int'(ack[i][1]), 0);
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            raise(i, 1, 1'b0, 8'h20, 8'h00);
            raise(i, 0, 1'b0, 8'h21, 8'h00);
        end
        repeat (18) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ar_acks%0d", i), order[i].size(), 2);
            if (order[i].size() > 0)
                chk($sformatf("ar_first%0d", i), order[i][0], 0);
        end

        // requester drops Req0 right after the grant
        clear_stats();
        for (int i = 0; i < 2; i++)
            raise(i, 0, 1'b0, 8'h05, 8'h00);
        tick();
        for (int i = 0; i < 2; i++) req[i][0] = 1'b0;
        repeat (12) tick();
        for (int i = 0; i < 2; i++)
            chk($sformatf("drop_acks%0d", i), nack[i][0], 1);

        // randomized traffic
        rnd_en = 1'b1;
        repeat (600) tick();
        rnd_en = 1'b0;
        repeat (20) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
